// File: rtl/line_tracker_if.sv
// ---------------------------------------------------------------------------
// line_tracker_if
// Bundles the line tracker's control and status signals.
//   en          tracking enable (master -> slave)
//   tube_in     raw tube sensor levels, 1 = line seen (master -> slave)
//   action      registered motion command (slave -> master)
//   action_chg  one-cycle pulse when action takes a new value (slave -> master)
//   lost        high while the tracker is searching for or has given up on
//               the line (slave -> master)
// ---------------------------------------------------------------------------
interface line_tracker_if #(
    parameter int N_SENS = 4
);
    logic              en;
    logic [N_SENS-1:0] tube_in;
    logic [3:0]        action;
    logic              action_chg;
    logic              lost;

    modport master (
        output en,
        output tube_in,
        input  action,
        input  action_chg,
        input  lost
    );

    modport slave (
        input  en,
        input  tube_in,
        output action,
        output action_chg,
        output lost
    );
endinterface

// File: rtl/line_tracker.sv
// ---------------------------------------------------------------------------
// line_tracker
// Turns a row of tube sensors into a motion command for a line-following
// vehicle. Raw sensor levels are synchronised, debounced, classified, and
// fed to a small state machine (IDLE / TRACK / SEARCH / HALT) that ramps
// straight-line speed and searches in the last known turn direction when
// the line disappears.
// Ports:
//   clk_in      system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus.slave   en, tube_in in; action, action_chg, lost out
// Latency: a pattern held from cycle t is reflected on action at t+DEBOUNCE+3.
// ---------------------------------------------------------------------------
module line_tracker #(
    parameter int N_SENS       = 4,
    parameter int DEBOUNCE     = 3,
    parameter int RAMP_CYCLES  = 8,
    parameter int LOST_TIMEOUT = 16
) (
    input  logic          clk_in,
    input  logic          rst_n,
    line_tracker_if.slave bus
);

    localparam logic [3:0] ACT_SLOW = 4'h1;
    localparam logic [3:0] ACT_NORM = 4'h2;
    localparam logic [3:0] ACT_FAST = 4'h3;
    localparam logic [3:0] ACT_TL   = 4'h4;
    localparam logic [3:0] ACT_TR   = 4'h5;
    localparam logic [3:0] ACT_STL  = 4'h6;
    localparam logic [3:0] ACT_STR  = 4'h7;
    localparam logic [3:0] ACT_STOP = 4'hF;

    localparam logic [7:0]  DB_LIM    = 8'(DEBOUNCE);
    localparam logic [16:0] RAMP_NORM = 17'(RAMP_CYCLES);
    localparam logic [16:0] RAMP_FAST = 17'(2 * RAMP_CYCLES);
    localparam logic [15:0] TO_LIM    = 16'(LOST_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_SEARCH, ST_HALT} state_t;
    typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_t;
    typedef enum logic [2:0] {
        CL_STOP, CL_LOST, CL_STL, CL_STR, CL_TL, CL_TR, CL_STRAIGHT
    } cls_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // First match wins, so the sharp-turn tests shadow the plain turns.
    function automatic cls_t classify(input logic [N_SENS-1:0] pat);
        logic [N_SENS/2-1:0] left;
        logic [N_SENS/2-1:0] right;
        left  = pat[N_SENS-1:N_SENS/2];
        right = pat[N_SENS/2-1:0];
        if (&pat)                              return CL_STOP;
        else if (pat == '0)                    return CL_LOST;
        else if (pat[N_SENS-1] && right == '0) return CL_STL;
        else if (pat[0] && left == '0)         return CL_STR;
        else if (left != '0 && right == '0)    return CL_TL;
        else if (right != '0 && left == '0)    return CL_TR;
        else                                   return CL_STRAIGHT;
    endfunction

    logic [N_SENS-1:0] sync_p0;
    logic [N_SENS-1:0] sync_p1;
    logic [N_SENS-1:0] cand_p2;
    logic [N_SENS-1:0] filt_p2;
    logic [7:0]        db_cnt;
    logic [7:0]        db_cnt_nxt;

    state_t      state, state_nxt;
    dir_t        last_dir, last_dir_nxt, trk_dir;
    logic [3:0]  action_q, action_nxt, trk_action;
    logic        action_chg_q;
    logic        lost_q;
    logic [16:0] ramp_cnt, ramp_nxt, trk_ramp, ramp_base;
    logic [15:0] to_cnt, to_nxt, to_inc;
    cls_t        cls;

    // Stage p0/p1: two-flop synchroniser. Stage p2: debounce filter; a new
    // candidate restarts the run count, and the filter accepts once the run
    // of identical samples reaches DEBOUNCE.
    always_comb begin
        db_cnt_nxt = (sync_p1 != cand_p2) ? 8'd1 : sat_inc8(db_cnt);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            cand_p2 <= '0;
            db_cnt  <= '0;
            filt_p2 <= '0;
        end else begin
            sync_p0 <= bus.tube_in;
            sync_p1 <= sync_p0;
            cand_p2 <= sync_p1;
            db_cnt  <= db_cnt_nxt;
            if (db_cnt_nxt >= DB_LIM)
                filt_p2 <= sync_p1;
        end
    end

    // Stage p3: classification and the command state machine.
    assign cls = classify(filt_p2);
    assign to_inc = sat_inc16(to_cnt);

    // Response to a non-LOST class. Coming out of SEARCH/HALT the ramp is
    // treated as empty so a straight always restarts at Slow.
    always_comb begin
        trk_action = ACT_STOP;
        trk_ramp   = '0;
        trk_dir    = last_dir;
        ramp_base  = (state == ST_TRACK) ? ramp_cnt : '0;
        case (cls)
            CL_STL: begin trk_action = ACT_STL; trk_dir = DIR_L; end
            CL_TL:  begin trk_action = ACT_TL;  trk_dir = DIR_L; end
            CL_STR: begin trk_action = ACT_STR; trk_dir = DIR_R; end
            CL_TR:  begin trk_action = ACT_TR;  trk_dir = DIR_R; end
            CL_STRAIGHT: begin
                if (ramp_base >= RAMP_FAST) begin
                    trk_action = ACT_FAST;
                    trk_ramp   = RAMP_FAST;
                end else begin
                    trk_action = (ramp_base >= RAMP_NORM) ? ACT_NORM : ACT_SLOW;
                    trk_ramp   = ramp_base + 17'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        action_nxt   = action_q;
        last_dir_nxt = last_dir;
        ramp_nxt     = ramp_cnt;
        to_nxt       = to_cnt;
        if (!bus.en) begin
            state_nxt  = ST_IDLE;
            action_nxt = ACT_STOP;
            ramp_nxt   = '0;
            to_nxt     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt  = ST_TRACK;
                    action_nxt = ACT_STOP;
                    ramp_nxt   = '0;
                    to_nxt     = '0;
                end
                ST_TRACK: begin
                    if (cls == CL_LOST) begin
                        state_nxt  = ST_SEARCH;
                        action_nxt = (last_dir == DIR_L) ? ACT_STL : ACT_STR;
                        ramp_nxt   = '0;
                        to_nxt     = '0;
                    end else begin
                        action_nxt   = trk_action;
                        ramp_nxt     = trk_ramp;
                        last_dir_nxt = trk_dir;
                    end
                end
                ST_SEARCH: begin
                    if (cls == CL_LOST) begin
                        to_nxt = to_inc;
                        if (to_inc >= TO_LIM) begin
                            state_nxt  = ST_HALT;
                            action_nxt = ACT_STOP;
                        end
                    end else begin
                        state_nxt    = ST_TRACK;
                        action_nxt   = trk_action;
                        ramp_nxt     = trk_ramp;
                        last_dir_nxt = trk_dir;
                        to_nxt       = '0;
                    end
                end
                ST_HALT: begin
                    action_nxt = ACT_STOP;
                    if (cls != CL_LOST) begin
                        state_nxt    = ST_TRACK;
                        action_nxt   = trk_action;
                        ramp_nxt     = trk_ramp;
                        last_dir_nxt = trk_dir;
                        to_nxt       = '0;
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    action_nxt = ACT_STOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            action_q     <= ACT_STOP;
            action_chg_q <= 1'b0;
            lost_q       <= 1'b0;
            last_dir     <= DIR_L;
            ramp_cnt     <= '0;
            to_cnt       <= '0;
        end else begin
            state        <= state_nxt;
            action_q     <= action_nxt;
            action_chg_q <= (action_nxt != action_q);
            lost_q       <= (state_nxt == ST_SEARCH) || (state_nxt == ST_HALT);
            last_dir     <= last_dir_nxt;
            ramp_cnt     <= ramp_nxt;
            to_cnt       <= to_nxt;
        end
    end

    assign bus.action     = action_q;
    assign bus.action_chg = action_chg_q;
    assign bus.lost       = lost_q;

endmodule

// File: tb/tb_line_tracker.sv
// ---------------------------------------------------------------------------
// tb_line_tracker
// Directed scenarios for line_tracker (N_SENS=4, DEBOUNCE=3, RAMP_CYCLES=8,
// LOST_TIMEOUT=16). The stimulus process pushes each expected output event
// (cycle, action, lost) into a queue; a monitor pops and compares whenever
// action or lost changes, and checks action_chg every cycle.
// ---------------------------------------------------------------------------
module tb_line_tracker;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] act;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];

    line_tracker_if #(.N_SENS(4)) ifc ();

    line_tracker #(
        .N_SENS(4), .DEBOUNCE(3), .RAMP_CYCLES(8), .LOST_TIMEOUT(16)
    ) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] a, input logic l);
        exp_t e;
        e.cyc = c; e.act = a; e.lost = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ifc.action !== 4'hF || ifc.lost !== 1'b0 || ifc.action_chg !== 1'b0) begin
            errors++;
            $display("FAIL %s: got action=%h lost=%b chg=%b, want action=f lost=0 chg=0",
                     tag, ifc.action, ifc.lost, ifc.action_chg);
        end
    endtask

    task automatic check_queue_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending expected events, want 0 (next at cyc %0d action=%h)",
                     tag, exp_q.size(), exp_q[0].cyc, exp_q[0].act);
        end
    endtask

    // Monitor
    logic [3:0] act_prev  = 4'hF;
    logic       lost_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            act_prev  = ifc.action;
            lost_prev = ifc.lost;
        end else begin
            checks++;
            if (ifc.action_chg !== (ifc.action != act_prev)) begin
                errors++;
                $display("FAIL action_chg@%0d: got %b, want %b (action %h -> %h)",
                         cyc, ifc.action_chg, (ifc.action != act_prev), act_prev, ifc.action);
            end
            if (ifc.action != act_prev || ifc.lost != lost_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event@%0d: got action=%h lost=%b, want no change",
                             cyc, ifc.action, ifc.lost);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.act !== ifc.action || e.lost !== ifc.lost) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d action=%h lost=%b, want cyc=%0d action=%h lost=%b",
                                 cyc, ifc.action, ifc.lost, e.cyc, e.act, e.lost);
                    end
                end
            end
            act_prev  = ifc.action;
            lost_prev = ifc.lost;
        end
    end

    // Stimulus
    initial begin
        int t;
        rst_n       = 1'b1;
        ifc.en      = 1'b0;
        ifc.tube_in = 4'b0000;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_assert");
        wait_cyc(3);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        wait_cyc(4);
        check_reset_outputs("reset_release");

        // Straight ramp latency: settle on all-ones Stop, then go straight.
        ifc.tube_in = 4'b1111;
        wait_cyc(10);
        ifc.en = 1'b1;
        wait_cyc(10);
        t = cyc;
        ifc.tube_in = 4'b0110;
        push(t + 6, 4'h1, 1'b0);
        push(t + 14, 4'h2, 1'b0);
        push(t + 22, 4'h3, 1'b0);
        wait_cyc(30);
        ifc.en = 1'b0;
        push(cyc + 1, 4'hF, 1'b0);
        wait_cyc(5);

        // Stop at Norm, ramp restart, and a 2-cycle glitch during the ramp.
        t = cyc;
        ifc.en = 1'b1;
        push(t + 2, 4'h1, 1'b0);
        push(t + 10, 4'h2, 1'b0);
        wait_cyc(12);
        t = cyc;
        ifc.tube_in = 4'b1111;
        push(t + 6, 4'hF, 1'b0);
        wait_cyc(10);
        t = cyc;
        ifc.tube_in = 4'b0110;
        push(t + 6, 4'h1, 1'b0);
        push(t + 14, 4'h2, 1'b0);
        push(t + 22, 4'h3, 1'b0);
        wait_cyc(8);
        ifc.tube_in = 4'b0000;
        wait_cyc(2);
        ifc.tube_in = 4'b0110;
        wait_cyc(20);

        // en dropped at Fast.
        ifc.en = 1'b0;
        push(cyc + 1, 4'hF, 1'b0);
        ifc.tube_in = 4'b1000;
        wait_cyc(10);

        // Sharp left, lose the line, time out to HALT, recover sharp right.
        t = cyc;
        ifc.en = 1'b1;
        push(t + 2, 4'h6, 1'b0);
        wait_cyc(6);
        t = cyc;
        ifc.tube_in = 4'b0000;
        push(t + 6, 4'h6, 1'b1);
        push(t + 22, 4'hF, 1'b1);
        wait_cyc(26);
        t = cyc;
        ifc.tube_in = 4'b0001;
        push(t + 6, 4'h7, 1'b0);
        wait_cyc(10);

        // Right turn sets last_dir=R; search goes right; left turn recovers.
        t = cyc;
        ifc.tube_in = 4'b0010;
        push(t + 6, 4'h5, 1'b0);
        wait_cyc(10);
        t = cyc;
        ifc.tube_in = 4'b0000;
        push(t + 6, 4'h7, 1'b1);
        wait_cyc(10);
        t = cyc;
        ifc.tube_in = 4'b0100;
        push(t + 6, 4'h4, 1'b0);
        wait_cyc(10);

        // Reset mid-SEARCH.
        t = cyc;
        ifc.tube_in = 4'b0000;
        push(t + 6, 4'h6, 1'b1);
        wait_cyc(10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_in_search");
        check_queue_empty("pending_before_reset");
        ifc.en      = 1'b0;
        ifc.tube_in = 4'b0110;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(10);
        t = cyc;
        ifc.en = 1'b1;
        push(t + 2, 4'h1, 1'b0);
        wait_cyc(5);
        ifc.en = 1'b0;
        push(cyc + 1, 4'hF, 1'b0);
        wait_cyc(5);

        check_queue_empty("pending_at_end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion by %0t, want completion", $time);
        $fatal(1, "bench time limit expired");
    end

endmodule
